// File: rtl/pipe_pkg.sv
// Shared opcode encodings and hazard-controller state type for the 5-stage RISC-V pipe.
package pipe_pkg;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {S_RUN, S_MEM_WAIT} hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational ID-vs-EX comparator: flags a load-use hazard and a branch/JALR operand hazard.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [6:0] opcode_id,
  input  logic [6:0] opcode_ex,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic [4:0] rd_ex,
  output logic       load_use,
  output logic       branch_stall
);

  logic lw_ex, rs1_hit, rs2_hit, br_id;

  assign lw_ex   = (opcode_ex == OP_LW) && (rd_ex != 5'd0);
  assign rs1_hit = use_rs1_id && (rs1_id == rd_ex);
  assign rs2_hit = use_rs2_id && (rs2_id == rd_ex);
  assign br_id   = (opcode_id == OP_BRANCH) || (opcode_id == OP_JALR);

  // A store's rs2 is only needed at MEM, where the load result forwards in time.
  assign load_use     = lw_ex && (rs1_hit || (rs2_hit && (opcode_id != OP_SW)));
  assign branch_stall = lw_ex && br_id && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stalls, redirects, MEM-wait freeze and watchdog.
// Optional perf counters (stall_cnt/flush_cnt) when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode_id,
  input  logic [6:0]       opcode_ex,
  input  logic [6:0]       opcode_mem,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             regwrite_ex,
  input  logic             branch_taken_id,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             ifid_flush,
  output logic             pc_redirect,
  output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int WAIT_W = 16;

  hz_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use, branch_stall, stall, freeze;

  // MEM-stage producers are always forwarded; an EX LW always writes rd.
  logic unused_inputs;
  assign unused_inputs = ^{opcode_mem, regwrite_ex};

  hazard_detect u_detect (
    .opcode_id    (opcode_id),
    .opcode_ex    (opcode_ex),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .use_rs1_id   (use_rs1_id),
    .use_rs2_id   (use_rs2_id),
    .rd_ex        (rd_ex),
    .load_use     (load_use),
    .branch_stall (branch_stall)
  );

  assign freeze = dmem_req && !dmem_ready;
  assign stall  = load_use || branch_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:      if (freeze)     state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: if (dmem_ready) state_nxt = S_RUN;
      default:                    state_nxt = S_RUN;
    endcase
  end

  // Outputs depend only on current inputs; the state just feeds the watchdog.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    ifid_flush   = 1'b0;
    pc_redirect  = 1'b0;
    if (!reset_n) begin
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (branch_taken_id) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == S_MEM_WAIT && state_nxt == S_MEM_WAIT) begin
      if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= WAIT_W'(WAIT_TIMEOUT - 1)) mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((freeze || stall) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && flush_cnt != '1)        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 16;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
                         BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  logic clk = 1'b0;
  logic reset_n;
  logic [6:0] opcode_id, opcode_ex, opcode_mem;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic use_rs1_id, use_rs2_id, regwrite_ex, branch_taken_id, dmem_req, dmem_ready;
  logic pc_write, ifid_write, idex_write, exmem_write, idex_bubble, memwb_bubble;
  logic ifid_flush, pc_redirect, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WAIT_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .opcode_id(opcode_id), .opcode_ex(opcode_ex), .opcode_mem(opcode_mem),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .regwrite_ex(regwrite_ex), .branch_taken_id(branch_taken_id),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .ifid_flush(ifid_flush), .pc_redirect(pc_redirect), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model: consecutive completed freeze cycles, sticky timeout, perf counts.
  int   consec;
  bit   tmo_m;
  int   stall_m, flush_m;

  task automatic model_clear();
    consec = 0; tmo_m = 0; stall_m = 0; flush_m = 0;
  endtask

  task automatic set_idle();
    opcode_id = 7'd0; opcode_ex = 7'd0; opcode_mem = 7'd0;
    rs1_id = 5'd0; rs2_id = 5'd0; use_rs1_id = 0; use_rs2_id = 0;
    rd_ex = 5'd0; regwrite_ex = 0; branch_taken_id = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  // Called right after inputs change at the negedge: check, then advance model at posedge.
  task automatic check_cycle(input string tag);
    bit fz, st, fl, dep1, dep2, lw;
    logic [7:0] exp, got;
    #2;
    if (!reset_n) model_clear();
    lw   = (opcode_ex == LW) && (rd_ex != 0);
    dep1 = use_rs1_id && (rs1_id == rd_ex);
    dep2 = use_rs2_id && (rs2_id == rd_ex);
    fz   = dmem_req && !dmem_ready;
    st   = lw && (dep1 || (dep2 && opcode_id != SW) ||
                  ((opcode_id == BR || opcode_id == JALR) && (dep1 || dep2)));
    fl   = !fz && !st && branch_taken_id;
    // {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, memwb_bubble, ifid_flush, pc_redirect}
    if (!reset_n)  exp = 8'b1111_1100;
    else if (fz)   exp = 8'b0000_0100;
    else if (st)   exp = 8'b0011_1000;
    else if (fl)   exp = 8'b1111_0011;
    else           exp = 8'b1111_0000;
    got = {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, memwb_bubble,
           ifid_flush, pc_redirect};
    chk({tag, ".ctl"}, 32'(got), 32'(exp));
    chk({tag, ".tmo"}, 32'(mem_timeout), 32'(tmo_m));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(stall_m));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(flush_m));
`endif
    @(posedge clk);
    if (reset_n) begin
      if (fz) begin
        consec++;
        if (consec >= TO + 1) tmo_m = 1;
      end else consec = 0;
      if ((fz || st) && stall_m < (1 << CNT_W) - 1) stall_m++;
      if (fl && flush_m < (1 << CNT_W) - 1) flush_m++;
    end
  endtask

  logic [6:0] ops [8];

  initial begin
    bit pending;
    ops = '{7'd0, LW, SW, RT, IT, BR, JAL, JALR};
    model_clear();
    set_idle();
    reset_n = 0;
    @(negedge clk); check_cycle("reset");
    @(negedge clk); check_cycle("reset2");
    @(negedge clk); reset_n = 1; check_cycle("idle");

    // LW x5 in EX, ADD x6,x5,x1 in ID: one stall cycle, then run
    @(negedge clk); opcode_ex = LW; rd_ex = 5; regwrite_ex = 1;
    opcode_id = RT; rs1_id = 5; rs2_id = 1; use_rs1_id = 1; use_rs2_id = 1;
    check_cycle("ldu_stall");
    @(negedge clk); opcode_ex = 7'd0; rd_ex = 0; regwrite_ex = 0; opcode_mem = LW;
    check_cycle("ldu_run");

    // LW x5 in EX, SW x5,0(x2) in ID: no stall
    @(negedge clk); set_idle(); opcode_ex = LW; rd_ex = 5; regwrite_ex = 1;
    opcode_id = SW; rs1_id = 2; rs2_id = 5; use_rs1_id = 1; use_rs2_id = 1;
    check_cycle("sw_nostall");

    // LW x5 in EX, BEQ x5,x0 taken: stall, no redirect; then redirect
    @(negedge clk); opcode_id = BR; rs1_id = 5; rs2_id = 0; branch_taken_id = 1;
    check_cycle("br_stall");
    @(negedge clk); opcode_ex = 7'd0; rd_ex = 0; regwrite_ex = 0;
    check_cycle("br_redirect");

    // Taken branch, no hazards
    @(negedge clk); set_idle(); opcode_id = BR; rs1_id = 3; rs2_id = 4;
    use_rs1_id = 1; use_rs2_id = 1; opcode_ex = RT; rd_ex = 3; regwrite_ex = 1; branch_taken_id = 1;
    check_cycle("redirect");
    @(negedge clk); set_idle(); check_cycle("post_redirect");

    // Ready after 3 cycles: 3 freeze cycles, ready cycle runs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_idle(); dmem_req = 1; check_cycle("freeze");
    end
    @(negedge clk); dmem_ready = 1; check_cycle("ready");
    @(negedge clk); set_idle(); check_cycle("post_ready");
    // Ready without request is ignored
    @(negedge clk); dmem_ready = 1; check_cycle("stray_ready");

    // Ready never arrives: watchdog trips and stays set
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); set_idle(); dmem_req = 1; check_cycle("timeout");
    end
    @(negedge clk); reset_n = 0; check_cycle("rst_mid_wait");
    @(negedge clk); reset_n = 1; set_idle(); check_cycle("after_rst");

    // Randomized traffic with a request held until ready
    pending = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 79) != 0);
      opcode_id = ops[$urandom_range(0, 7)];
      opcode_ex = ops[$urandom_range(0, 7)];
      opcode_mem = ops[$urandom_range(0, 7)];
      rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
      rd_ex  = 5'($urandom_range(0, 3));
      use_rs1_id = 1'($urandom); use_rs2_id = 1'($urandom);
      regwrite_ex = 1'($urandom); branch_taken_id = 1'($urandom);
      if (!reset_n) begin
        pending = 0; dmem_req = 0; dmem_ready = 1'($urandom);
      end else if (pending) begin
        dmem_req = 1; dmem_ready = ($urandom_range(0, 3) == 0);
        if (dmem_ready) pending = 0;
      end else begin
        dmem_req = ($urandom_range(0, 4) == 0); dmem_ready = 1'($urandom);
        if (dmem_req && !dmem_ready) pending = 1;
      end
      check_cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
